// File: rtl/rr_arbiter.sv
// Registered N-way arbiter: fixed-priority or round-robin selection from two
// priority encoders, with optional grant hold until request drop or acknowledge.

module rr_prio_enc #(
   parameter int W        = 4,
   parameter int LSB_HIGH = 0
) (
   input  logic [W-1:0]         req_i,
   output logic                 valid_o,
   output logic [$clog2(W)-1:0] idx_o
);
   localparam int IW = $clog2(W);

   always_comb begin
      valid_o = |req_i;
      idx_o   = '0;
      // The last matching bit visited is the winner, so scan towards the highest priority.
      if (LSB_HIGH != 0) begin
         for (int i = W - 1; i >= 0; i--) begin
            if (req_i[i]) idx_o = IW'(i);
         end
      end else begin
         for (int i = 0; i < W; i++) begin
            if (req_i[i]) idx_o = IW'(i);
         end
      end
   end
endmodule

module rr_arbiter #(
   parameter int PORTS                = 4,
   parameter int ARB_TYPE_ROUND_ROBIN = 0,
   parameter int ARB_BLOCK            = 0,
   parameter int ARB_BLOCK_ACK        = 1,
   parameter int LSB_HIGH_PRIORITY    = 0
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [PORTS-1:0]         request,
   input  logic [PORTS-1:0]         acknowledge,
   output logic [PORTS-1:0]         grant,
   output logic                     grant_valid,
   output logic [$clog2(PORTS)-1:0] grant_encoded
);
   localparam int IW = $clog2(PORTS);

   logic [PORTS-1:0] grant_q, grant_d;
   logic [PORTS-1:0] mask_q, mask_d;
   logic             valid_q, valid_d;
   logic [IW-1:0]    enc_q, enc_d;

   logic             a_valid, b_valid;
   logic [IW-1:0]    a_idx, b_idx;
   logic [IW-1:0]    win_idx;
   logic             hold;

   rr_prio_enc #(.W(PORTS), .LSB_HIGH(LSB_HIGH_PRIORITY)) u_enc_a (
      .req_i   (request),
      .valid_o (a_valid),
      .idx_o   (a_idx)
   );

   rr_prio_enc #(.W(PORTS), .LSB_HIGH(LSB_HIGH_PRIORITY)) u_enc_b (
      .req_i   (request & mask_q),
      .valid_o (b_valid),
      .idx_o   (b_idx)
   );

   always_comb begin
      hold = 1'b0;
      if (ARB_BLOCK != 0 && valid_q) begin
         if (ARB_BLOCK_ACK != 0) hold = request[enc_q] && !acknowledge[enc_q];
         else                    hold = request[enc_q];
      end

      win_idx = (ARB_TYPE_ROUND_ROBIN != 0 && b_valid) ? b_idx : a_idx;

      grant_d = grant_q;
      valid_d = valid_q;
      enc_d   = enc_q;
      mask_d  = mask_q;

      // Encoded index is left alone on idle cycles; only grant/valid drop.
      if (!hold) begin
         grant_d = '0;
         valid_d = 1'b0;
         if (a_valid) begin
            grant_d[win_idx] = 1'b1;
            valid_d          = 1'b1;
            enc_d            = win_idx;
            if (ARB_TYPE_ROUND_ROBIN != 0) begin
               for (int j = 0; j < PORTS; j++) begin
                  mask_d[j] = (LSB_HIGH_PRIORITY != 0) ? (j > int'(win_idx))
                                                       : (j < int'(win_idx));
               end
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         grant_q <= '0;
         valid_q <= 1'b0;
         enc_q   <= '0;
         mask_q  <= '1;
      end else begin
         grant_q <= grant_d;
         valid_q <= valid_d;
         enc_q   <= enc_d;
         mask_q  <= mask_d;
      end
   end

   assign grant         = grant_q;
   assign grant_valid   = valid_q;
   assign grant_encoded = enc_q;
endmodule
